// File: rtl/pcie2_x1_lsm.sv
// Receive-lane sync state machine, 2 symbols per rec_clk.
// Acquires lane sync on clean K28.5 commas, drops it on accumulated symbol errors with
// good-run hysteresis, and keeps a sticky saturating loss-of-sync event count.
module pcie2_x1_lsm #(
  parameter int unsigned NUM_COMMA = 4,
  parameter int unsigned GOOD_RUN  = 4,
  parameter int unsigned BAD_MAX   = 4
) (
  input  logic        rec_clk,
  input  logic        rst_n,
  input  logic        lsm_en,
  input  logic        force_sync,
  input  logic        elec_idle,
  input  logic [15:0] d_in,
  input  logic [1:0]  k_in,
  input  logic [1:0]  cv_in,
  input  logic [1:0]  de_in,
  input  logic        cnt_clr,
  output logic [15:0] d_out,
  output logic [1:0]  k_out,
  output logic [1:0]  sym_err,
  output logic        lsyn_out,
  output logic        los_event,
  output logic [7:0]  los_cnt
);

  localparam int unsigned CcW = $clog2(NUM_COMMA + 1);
  localparam int unsigned GcW = $clog2(GOOD_RUN + 1);
  localparam int unsigned BcW = $clog2(BAD_MAX + 1);

  localparam logic [CcW-1:0] CcOne  = CcW'(1);
  localparam logic [CcW-1:0] CcLast = CcW'(NUM_COMMA - 1);
  localparam logic [GcW-1:0] GcOne  = GcW'(1);
  localparam logic [GcW-1:0] GcLast = GcW'(GOOD_RUN - 1);
  localparam logic [BcW-1:0] BcOne  = BcW'(1);
  localparam logic [BcW-1:0] BcLast = BcW'(BAD_MAX - 1);

  typedef enum logic [1:0] {
    StLos    = 2'd0,
    StAcq    = 2'd1,
    StSync   = 2'd2,
    StResync = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CcW-1:0] comma_cnt_q, comma_cnt_d;
  logic [GcW-1:0] good_cnt_q, good_cnt_d;
  logic [BcW-1:0] bad_cnt_q, bad_cnt_d;
  logic           los_hit;
  logic           sym_bad;
  logic           sym_comma;

  // Next state: overrides first, otherwise walk the [15:8] symbol then the [7:0] symbol.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    los_hit     = 1'b0;
    sym_bad     = 1'b0;
    sym_comma   = 1'b0;
    if (!lsm_en || elec_idle) begin
      state_d     = StLos;
      comma_cnt_d = '0;
      good_cnt_d  = '0;
      bad_cnt_d   = '0;
      los_hit     = (state_q == StSync) || (state_q == StResync);
    end else begin
      for (int i = 1; i >= 0; i--) begin
        sym_bad   = cv_in[i] | de_in[i];
        sym_comma = k_in[i] & (d_in[8*i +: 8] == 8'hBC) & ~sym_bad;
        unique case (state_d)
          StLos: begin
            if (sym_comma) begin
              state_d     = StAcq;
              comma_cnt_d = CcOne;
            end
          end
          StAcq: begin
            if (sym_bad) begin
              state_d     = StLos;
              comma_cnt_d = '0;
            end else if (sym_comma) begin
              if (comma_cnt_d >= CcLast) begin
                state_d     = StSync;
                comma_cnt_d = '0;
              end else begin
                comma_cnt_d = comma_cnt_d + CcOne;
              end
            end
          end
          StSync: begin
            if (sym_bad) begin
              state_d    = StResync;
              bad_cnt_d  = BcOne;
              good_cnt_d = '0;
            end
          end
          StResync: begin
            if (sym_bad) begin
              good_cnt_d = '0;
              if (bad_cnt_d >= BcLast) begin
                state_d   = StLos;
                bad_cnt_d = '0;
                los_hit   = 1'b1;
              end else begin
                bad_cnt_d = bad_cnt_d + BcOne;
              end
            end else if (good_cnt_d >= GcLast) begin
              // A full good run pays back one bad credit.
              good_cnt_d = '0;
              bad_cnt_d  = bad_cnt_d - BcOne;
              if (bad_cnt_d == '0) state_d = StSync;
            end else begin
              good_cnt_d = good_cnt_d + GcOne;
            end
          end
          default: state_d = StLos;
        endcase
      end
    end
  end

  // FSM state and hysteresis counters.
  always_ff @(posedge rec_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLos;
      comma_cnt_q <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  // One-cycle data pipeline, loss pulse and sticky loss counter (clear wins).
  always_ff @(posedge rec_clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out     <= '0;
      k_out     <= '0;
      sym_err   <= '0;
      los_event <= 1'b0;
      los_cnt   <= '0;
    end else begin
      d_out     <= d_in;
      k_out     <= k_in;
      sym_err   <= cv_in | de_in;
      los_event <= los_hit;
      if (cnt_clr) begin
        los_cnt <= '0;
      end else if (los_hit && (los_cnt != 8'hFF)) begin
        los_cnt <= los_cnt + 8'd1;
      end
    end
  end

  // Sync flag follows the registered state so it lines up with d_out.
  always_comb begin
    lsyn_out = force_sync | (state_q == StSync) | (state_q == StResync);
  end

endmodule
